// File: rtl/pn_sched4.sv
// pn_sched4: two-stage swap-control scheduler for a 4-input permutation
// network of 2x2 age-compare cells. P1 captures a timestamp set and the tie
// mode. P2 holds the stage-1/stage-2 swap controls and the final slot order.
// The block also owns the injection age counter and the tie-break mode timer.
`ifndef TIME_WIDTH
`define TIME_WIDTH 8
`endif

module pn_sched4 #(
    parameter int TIME_W      = `TIME_WIDTH,
    parameter int MODE_PERIOD = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [4*TIME_W-1:0]   in_time,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [1:0]            s1_swap,
    output logic [1:0]            s2_swap,
    output logic [4*TIME_W-1:0]   out_time,
    output logic                  out_mode,
    output logic [TIME_W-1:0]     now_time
);

    localparam int MCNT_W = 16;

    typedef logic [TIME_W-1:0] stamp_t;

    localparam stamp_t STAMP_ONES = {TIME_W{1'b1}};
    localparam stamp_t STAMP_ZERO = {TIME_W{1'b0}};
    localparam stamp_t STAMP_ONE  = {{(TIME_W-1){1'b0}}, 1'b1};
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MODE_PERIOD - 1);

    // An empty slot (time 0) ranks below every real flit.
    function automatic stamp_t key_of(input stamp_t t);
        return (t == STAMP_ZERO) ? STAMP_ONES : t;
    endfunction

    // Swap when the lower-port flit is older; in mode 1 an equal pair swaps too,
    // so the older flit always ends on the upper port.
    function automatic logic cell_swap(input stamp_t k_up, input stamp_t k_lo, input logic mode);
        return mode ? (k_lo <= k_up) : (k_lo < k_up);
    endfunction

    logic                  p1_vld_r;
    logic [4*TIME_W-1:0]   p1_time_r;
    logic                  p1_mode_r;
    logic                  p2_vld_r;
    logic [1:0]            s1_r;
    logic [1:0]            s2_r;
    logic [4*TIME_W-1:0]   p2_time_r;
    logic                  p2_mode_r;
    logic [MCNT_W-1:0]     mcnt_r;
    logic                  mode_r;
    stamp_t                now_r;

    logic                  p2_adv_s;
    stamp_t                in_slot_s [4];
    stamp_t                mid_s [4];
    stamp_t                fin_s [4];
    logic [1:0]            s1_s;
    logic [1:0]            s2_s;
    logic [4*TIME_W-1:0]   fin_pack_s;

    assign p2_adv_s = out_rdy || !p2_vld_r;
    assign in_rdy   = !p1_vld_r || p2_adv_s;

    assign out_vld  = p2_vld_r;
    assign s1_swap  = s1_r;
    assign s2_swap  = s2_r;
    assign out_time = p2_time_r;
    assign out_mode = p2_mode_r;
    assign now_time = now_r;

    // Swap controls and final slot order for the set held in P1.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_slot_s[i] = p1_time_r[i*TIME_W +: TIME_W];
        end
        s1_s[0]  = cell_swap(key_of(in_slot_s[0]), key_of(in_slot_s[1]), p1_mode_r);
        s1_s[1]  = cell_swap(key_of(in_slot_s[2]), key_of(in_slot_s[3]), p1_mode_r);
        mid_s[0] = s1_s[0] ? in_slot_s[1] : in_slot_s[0];
        mid_s[1] = s1_s[0] ? in_slot_s[0] : in_slot_s[1];
        mid_s[2] = s1_s[1] ? in_slot_s[3] : in_slot_s[2];
        mid_s[3] = s1_s[1] ? in_slot_s[2] : in_slot_s[3];
        s2_s[0]  = cell_swap(key_of(mid_s[0]), key_of(mid_s[2]), p1_mode_r);
        s2_s[1]  = cell_swap(key_of(mid_s[1]), key_of(mid_s[3]), p1_mode_r);
        fin_s[0] = s2_s[0] ? mid_s[2] : mid_s[0];
        fin_s[2] = s2_s[0] ? mid_s[0] : mid_s[2];
        fin_s[1] = s2_s[1] ? mid_s[3] : mid_s[1];
        fin_s[3] = s2_s[1] ? mid_s[1] : mid_s[3];
        fin_pack_s = {fin_s[3], fin_s[2], fin_s[1], fin_s[0]};
    end

    // Pipeline registers: P2 drains on out_rdy, P1 refills whenever in_rdy.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_vld_r  <= 1'b0;
            p1_time_r <= {(4*TIME_W){1'b0}};
            p1_mode_r <= 1'b0;
            p2_vld_r  <= 1'b0;
            s1_r      <= 2'b00;
            s2_r      <= 2'b00;
            p2_time_r <= {(4*TIME_W){1'b0}};
            p2_mode_r <= 1'b0;
        end else begin
            if (p2_adv_s) begin
                p2_vld_r <= p1_vld_r;
                if (p1_vld_r) begin
                    s1_r      <= s1_s;
                    s2_r      <= s2_s;
                    p2_time_r <= fin_pack_s;
                    p2_mode_r <= p1_mode_r;
                end
            end
            if (in_rdy) begin
                p1_vld_r <= in_vld;
                if (in_vld) begin
                    p1_time_r <= in_time;
                    p1_mode_r <= mode_r;
                end
            end
        end
    end

    // Tie-break mode timer: flips the mode once every MODE_PERIOD cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcnt_r <= {MCNT_W{1'b0}};
            mode_r <= 1'b0;
        end else if (mcnt_r == MCNT_LAST) begin
            mcnt_r <= {MCNT_W{1'b0}};
            mode_r <= ~mode_r;
        end else begin
            mcnt_r <= mcnt_r + {{(MCNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Injection age stamp: free-running, skips 0 because 0 marks an empty slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            now_r <= STAMP_ONE;
        end else if (now_r == STAMP_ONES) begin
            now_r <= STAMP_ONE;
        end else begin
            now_r <= now_r + STAMP_ONE;
        end
    end

endmodule

// File: tb/tb_pn_sched4.sv
// Testbench for pn_sched4: hand-computed vector table, scoreboard-checked
// streams with backpressure, age-stamp wrap and mid-stream reset sequences.
`ifndef TIME_WIDTH
`define TIME_WIDTH 8
`endif

module tb_pn_sched4;
    localparam int TW = `TIME_WIDTH;
    localparam int MP = 16;
    localparam int PW = 4 * TW;

    typedef logic [PW-1:0] pack_t;
    typedef struct { pack_t tin; logic md; logic [1:0] s1; logic [1:0] s2; pack_t tout; } vec_t;
    typedef struct { logic [1:0] s1; logic [1:0] s2; pack_t tout; logic md; } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_vld;
    logic          in_rdy;
    logic [PW-1:0] in_time;
    logic          out_vld;
    logic          out_rdy;
    logic [1:0]    s1_swap;
    logic [1:0]    s2_swap;
    logic [PW-1:0] out_time;
    logic          out_mode;
    logic [TW-1:0] now_time;

    pn_sched4 #(.TIME_W(TW), .MODE_PERIOD(MP)) dut (
        .clk(clk), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy), .in_time(in_time),
        .out_vld(out_vld), .out_rdy(out_rdy), .s1_swap(s1_swap), .s2_swap(s2_swap),
        .out_time(out_time), .out_mode(out_mode), .now_time(now_time)
    );

    always #5 clk = ~clk;

    int      n_cmp = 0;
    int      n_err = 0;
    exp_t    sb[$];
    exp_t    cur_exp;
    logic    use_model;
    int      mcnt_m;
    logic    mode_m;
    logic [TW-1:0] now_m;
    logic    stall_prev;
    logic [1:0] hold_s1, hold_s2;
    pack_t   hold_time;
    logic    hold_mode;
    vec_t    tab[12];
    logic    rnd_done;

    function automatic pack_t pk(input int a, input int b, input int c, input int d);
        pack_t p;
        p = '0;
        p[0*TW +: TW] = TW'(a);
        p[1*TW +: TW] = TW'(b);
        p[2*TW +: TW] = TW'(c);
        p[3*TW +: TW] = TW'(d);
        return p;
    endfunction

    function automatic int keyv(input logic [TW-1:0] t);
        return (t == 0) ? ((1 << TW) - 1) : int'(t);
    endfunction

    // true when flit c (lower port) must move above flit u
    function automatic logic beats(input logic [TW-1:0] c, input logic [TW-1:0] u, input logic md);
        if (keyv(c) < keyv(u)) return 1'b1;
        if (keyv(c) == keyv(u)) return md;
        return 1'b0;
    endfunction

    function automatic exp_t model(input pack_t tin, input logic md);
        logic [TW-1:0] a[4];
        logic [TW-1:0] m[4];
        logic [TW-1:0] f[4];
        exp_t e;
        for (int i = 0; i < 4; i++) a[i] = tin[i*TW +: TW];
        e.s1[0] = beats(a[1], a[0], md);
        e.s1[1] = beats(a[3], a[2], md);
        m[0] = e.s1[0] ? a[1] : a[0];  m[1] = e.s1[0] ? a[0] : a[1];
        m[2] = e.s1[1] ? a[3] : a[2];  m[3] = e.s1[1] ? a[2] : a[3];
        e.s2[0] = beats(m[2], m[0], md);
        e.s2[1] = beats(m[3], m[1], md);
        f[0] = e.s2[0] ? m[2] : m[0];  f[2] = e.s2[0] ? m[0] : m[2];
        f[1] = e.s2[1] ? m[3] : m[1];  f[3] = e.s2[1] ? m[1] : m[3];
        e.tout = {f[3], f[2], f[1], f[0]};
        e.md = md;
        return e;
    endfunction

    task automatic chk(input string name, input pack_t act, input pack_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference mode timer and age stamp.
    always @(posedge clk) begin
        if (reset) begin
            mcnt_m <= 0;
            mode_m <= 1'b0;
            now_m  <= TW'(1);
        end else begin
            if (mcnt_m == MP - 1) begin
                mcnt_m <= 0;
                mode_m <= ~mode_m;
            end else begin
                mcnt_m <= mcnt_m + 1;
            end
            now_m <= (now_m == {TW{1'b1}}) ? TW'(1) : now_m + TW'(1);
        end
    end

    // Monitor on the falling edge: scoreboard push/pop, stall stability, age stamp.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            chk("now_time", pack_t'(now_time), pack_t'(now_m));
            if (stall_prev) begin
                chk("hold_vld", pack_t'(out_vld), pack_t'(1'b1));
                chk("hold_s1", pack_t'(s1_swap), pack_t'(hold_s1));
                chk("hold_s2", pack_t'(s2_swap), pack_t'(hold_s2));
                chk("hold_time", out_time, hold_time);
                chk("hold_mode", pack_t'(out_mode), pack_t'(hold_mode));
            end
            if (out_vld && out_rdy) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got out_time %0h expected no output", out_time);
                end else begin
                    e = sb.pop_front();
                    chk("s1_swap", pack_t'(s1_swap), pack_t'(e.s1));
                    chk("s2_swap", pack_t'(s2_swap), pack_t'(e.s2));
                    chk("out_time", out_time, e.tout);
                    chk("out_mode", pack_t'(out_mode), pack_t'(e.md));
                end
            end
            stall_prev = out_vld && !out_rdy;
            hold_s1 = s1_swap;
            hold_s2 = s2_swap;
            hold_time = out_time;
            hold_mode = out_mode;
            if (in_vld && in_rdy) begin
                if (use_model) sb.push_back(model(in_time, mode_m));
                else sb.push_back(cur_exp);
            end
        end
    end

    // Present one set and hold it until the handshake edge has passed.
    task automatic send(input pack_t tin, input exp_t e);
        int k;
        cur_exp = e;
        in_time = tin;
        in_vld  = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_rdy) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_rdy 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int k;
        out_rdy = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("sb_drained", pack_t'(sb.size()), pack_t'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t nul;
        int w, zeros, wraps;
        logic [TW-1:0] prev;
        nul = '{s1: 2'b00, s2: 2'b00, tout: '0, md: 1'b0};
        tab[0]  = '{pk(9,2,7,5), 1'b0, 2'b11, 2'b10, pk(2,7,5,9)};
        tab[1]  = '{pk(5,5,5,5), 1'b0, 2'b00, 2'b00, pk(5,5,5,5)};
        tab[2]  = '{pk(0,3,0,0), 1'b0, 2'b01, 2'b00, pk(3,0,0,0)};
        tab[3]  = '{pk(0,0,0,0), 1'b0, 2'b00, 2'b00, pk(0,0,0,0)};
        tab[4]  = '{pk(1,2,3,4), 1'b0, 2'b00, 2'b00, pk(1,2,3,4)};
        tab[5]  = '{pk(4,3,2,1), 1'b0, 2'b11, 2'b11, pk(1,2,3,4)};
        tab[6]  = '{pk(5,0,5,0), 1'b0, 2'b00, 2'b00, pk(5,0,5,0)};
        tab[7]  = '{pk(5,5,5,5), 1'b1, 2'b11, 2'b11, pk(5,5,5,5)};
        tab[8]  = '{pk(0,0,0,0), 1'b1, 2'b11, 2'b11, pk(0,0,0,0)};
        tab[9]  = '{pk(5,0,5,0), 1'b1, 2'b00, 2'b11, pk(5,0,5,0)};
        tab[10] = '{pk(4,3,2,1), 1'b1, 2'b11, 2'b11, pk(1,2,3,4)};
        tab[11] = '{pk(0,3,0,0), 1'b1, 2'b11, 2'b10, pk(3,0,0,0)};

        reset = 1'b1; in_vld = 1'b0; in_time = '0; out_rdy = 1'b1;
        use_model = 1'b0; stall_prev = 1'b0; rnd_done = 1'b0; cur_exp = nul;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_vld", pack_t'(out_vld), pack_t'(0));
        chk("rst_s1", pack_t'(s1_swap), pack_t'(0));
        chk("rst_s2", pack_t'(s2_swap), pack_t'(0));
        chk("rst_out_time", out_time, pack_t'(0));
        chk("rst_out_mode", pack_t'(out_mode), pack_t'(0));
        chk("rst_now_time", pack_t'(now_time), pack_t'(1));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rdy_after_reset", pack_t'(in_rdy), pack_t'(1));
        @(posedge clk); #1;

        // table vectors, each presented when the reference mode matches
        for (int i = 0; i < 12; i++) begin
            w = 0;
            while (mode_m != tab[i].md && w < 4 * MP) begin
                @(posedge clk); #1;
                w++;
            end
            chk("tab_mode_wait", pack_t'(mode_m), pack_t'(tab[i].md));
            send(tab[i].tin, '{s1: tab[i].s1, s2: tab[i].s2, tout: tab[i].tout, md: tab[i].md});
        end
        drain();

        // backpressure: two sets fill P1/P2, then in_rdy must stay low
        use_model = 1'b1;
        out_rdy = 1'b0;
        send(pk(11,12,0,13), nul);
        send(pk(0,21,22,0), nul);
        in_time = pk(31,0,32,33);
        in_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_rdy", pack_t'(in_rdy), pack_t'(0));
            chk("bp_out_vld", pack_t'(out_vld), pack_t'(1));
        end
        @(posedge clk); #1;
        out_rdy = 1'b1;
        send(pk(31,0,32,33), nul);
        send(pk(41,42,43,44), nul);
        send(pk(54,53,52,51), nul);
        drain();

        // random stream with random backpressure, spanning several mode periods
        fork
            begin
                for (int i = 0; i < 60; i++)
                    send(pk($urandom_range(0,6), $urandom_range(0,6), $urandom_range(0,6), $urandom_range(0,6)), nul);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_rdy = ($urandom_range(0,2) != 0);
                end
            end
        join
        drain();

        // age stamp wrap over a full period
        zeros = 0; wraps = 0;
        @(negedge clk);
        prev = now_time;
        for (int i = 0; i < (1 << TW) + 8; i++) begin
            @(negedge clk);
            if (now_time == '0) zeros++;
            if (prev == {TW{1'b1}} && now_time == TW'(1)) wraps++;
            prev = now_time;
        end
        chk("now_never_zero", pack_t'(zeros), pack_t'(0));
        chk("now_wrap_to_1", pack_t'(wraps), pack_t'(1));

        // reset with P1 and P2 full; reset wins over a simultaneous in_vld
        @(posedge clk); #1;
        out_rdy = 1'b0;
        send(pk(61,62,63,64), nul);
        send(pk(71,72,73,74), nul);
        in_time = pk(81,82,83,84);
        in_vld = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        in_vld = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_out_vld", pack_t'(out_vld), pack_t'(0));
        chk("mid_rst_now", pack_t'(now_time), pack_t'(1));
        chk("mid_rst_in_rdy", pack_t'(in_rdy), pack_t'(1));
        out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_ghost", pack_t'(out_vld), pack_t'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
